pcpi_dot8_mac: RTL and testbench
================================

Name: pcpi_dot8_mac

Overview:
PCPI coprocessor for the PicoRV32 in the approximation SoC. It consumes the same packed 4x8-bit operand format as the packed-lane multiplier and reduces the four lane products into a persistent 32-bit accumulator. Each dot-product instruction is multi-cycle, processing one lane per clock. It sits on the shared PCPI bus next to the lane multiplier, which claims funct7=0000000; this block claims its own funct7.

Parameters:
FUNCT7, 7'b0000001, funct7 value claimed under custom-0 opcode 7'b0001011.
SIGNED_LANES, 0, 0 = lanes unsigned 8-bit; 1 = lanes two's-complement 8-bit, each product sign-extended to 32 bits before adding.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
pcpi_valid  input  1  CPU instruction offer
pcpi_insn  input  32  instruction word
pcpi_rs1  input  32  packed lanes A (lane i = bits 8i+7:8i)
pcpi_rs2  input  32  packed lanes B
pcpi_wr  output  1  write rd, pulses with pcpi_ready
pcpi_rd  output  32  result
pcpi_wait  output  1  busy, instruction claimed
pcpi_ready  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (reset). Reset forces state IDLE, accumulator 0, lane counter 0, and all outputs 0. This applies mid-operation too: an in-flight DOT is discarded with no ready and no accumulator change.
- Claim condition: active = pcpi_valid && insn[6:0]==7'b0001011 && insn[31:25]==FUNCT7 && funct3 in {000,001,010,011}. No other value of funct3 or funct7 ever asserts wait, ready or wr, so the CPU times out to an illegal-instruction trap.
- funct3 encoding:
  - 000 DOT: acc <= acc + sum.
  - 001 DOTZ: acc <= sum.
  - 010 RDACC: rd = acc.
  - 011 CLRACC: acc <= 0, rd = 0.
- sum = sum over i=0..3 of A[i]*B[i]. Each product is 16 bits, and the sum fits in 18 bits unsigned. Accumulator addition wraps modulo 2^32 with no saturation or flag.
- States: IDLE, MUL, DONE.
- IDLE:
  - On an edge with active and funct3 in {010,011}: pcpi_ready=1, pcpi_wr=1, pcpi_rd set (acc, or 0) in the following cycle. CLRACC clears acc on the same edge. State stays IDLE, giving 1-cycle latency.
  - On an edge with active and funct3 in {000,001}: latch rs1, rs2 and funct3, clear the partial sum, set lane=0, pcpi_wait=1, state goes to MUL.
- MUL: each edge adds product(lane) to the partial sum and increments lane.
  - On the edge processing lane 3: acc is updated, pcpi_rd = new acc, pcpi_ready=1, pcpi_wr=1, pcpi_wait=0, state goes to DONE.
  - Result: ready is high in the 5th cycle after the accept edge. Operands are taken from the latched copies, not the live bus.
- Abort: if pcpi_valid is sampled low on any MUL edge, go to IDLE, clear wait, leave acc unchanged, and assert no ready.
- DONE: ready, wr and wait go to 0 on the next edge, then IDLE. pcpi_valid is ignored in DONE, which prevents re-triggering on a stale valid. A new instruction is accepted from the cycle after DONE.
- Pulse width and hold: pcpi_ready and pcpi_wr are single-cycle pulses in every path. pcpi_rd holds its last value otherwise.
- Accumulator persistence: the accumulator persists across instructions. Only DOT, DOTZ, CLRACC and reset modify it.

Test Plan:
- DOTZ: rs1=0x01020304, rs2=0x05060708 -> lane products 32+21+12+5. Ready and wr pulse exactly 5 cycles after the accept edge with rd=0x00000046. Wait is high for the 4 preceding cycles.
- DOT repeated with the same operands -> rd=0x0000008C. Then RDACC -> ready 1 cycle after offer, rd=0x0000008C. Then CLRACC -> rd=0. A following RDACC -> rd=0.
- Unsigned max: DOTZ with 0xFFFFFFFF x 0xFFFFFFFF -> rd=0x0003F804.
  - With SIGNED_LANES=1 the same operands -> rd=0x00000004.
  - With SIGNED_LANES=1, 0x80808080 x 0x7F7F7F7F -> rd=0xFFFF0200.
- Wrap: issue DOT with 0xFFFFFFFF operands 16513 times from acc=0 -> acc = 16513*260100 mod 2^32. No ready glitches between instructions.
- Non-claim: funct7=0000000 or funct3=100 with valid held 20 cycles -> wait, ready and wr stay 0 and acc is unchanged.
- Abort and reset: drop valid in the 2nd MUL cycle -> no ready, acc unchanged, next RDACC returns the prior value. Assert reset in the 3rd MUL cycle -> all outputs 0 next cycle, and RDACC returns 0.

Source files
------------

// File: rtl/pcpi_dot8_mac.sv
// pcpi_dot8_mac: PCPI coprocessor computing a 4x8-bit dot product of the
// packed lanes in rs1/rs2 and folding it into a persistent 32-bit accumulator.
// One lane is processed per clock. RDACC/CLRACC complete in a single cycle.
//
// Handshake: the CPU holds pcpi_valid with a stable instruction until it sees
// pcpi_ready. pcpi_wait is high while a claimed DOT/DOTZ is in flight.
// pcpi_ready and pcpi_wr pulse together for exactly one cycle, with pcpi_rd
// valid in that cycle. pcpi_rd holds its last value otherwise. If valid drops
// while a DOT is in flight, the operation is abandoned silently.
module pcpi_dot8_mac #(
  parameter logic [6:0] FUNCT7       = 7'b0000001,
  parameter int         SIGNED_LANES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  // State register, left visible by name for hierarchical observation.
  state_t      state;
  logic [31:0] acc;
  logic [31:0] psum;
  logic [1:0]  lane;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_dotz;

  // Instruction decode.
  logic [6:0] insn_opcode;
  logic [2:0] insn_funct3;
  logic [6:0] insn_funct7;
  logic       active;
  logic       unused_insn_bits;

  assign insn_opcode = pcpi_insn[6:0];
  assign insn_funct3 = pcpi_insn[14:12];
  assign insn_funct7 = pcpi_insn[31:25];
  // Register fields are the CPU's business; this block only uses rs1/rs2 values.
  assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // Only funct3 values 000..011 are claimed; anything else is left unanswered
  // so the CPU traps on it.
  assign active = pcpi_valid
               && (insn_opcode == OPC_CUSTOM0)
               && (insn_funct7 == FUNCT7)
               && !insn_funct3[2];

  // Select the latched operand bytes for the lane being processed.
  logic [7:0] a_byte;
  logic [7:0] b_byte;

  // Lane multiplexer over the latched operands.
  always_comb begin
    a_byte = op_a[7:0];
    b_byte = op_b[7:0];
    case (lane)
      2'd0: begin a_byte = op_a[7:0];   b_byte = op_b[7:0];   end
      2'd1: begin a_byte = op_a[15:8];  b_byte = op_b[15:8];  end
      2'd2: begin a_byte = op_a[23:16]; b_byte = op_b[23:16]; end
      default: begin a_byte = op_a[31:24]; b_byte = op_b[31:24]; end
    endcase
  end

  // Lane product, widened to 32 bits by sign or zero extension.
  logic signed [15:0] prod_s;
  logic        [15:0] prod_u;
  logic        [31:0] prod_ext;
  logic        [31:0] lane_sum;
  logic        [31:0] acc_next;

  assign prod_s   = $signed(a_byte) * $signed(b_byte);
  assign prod_u   = a_byte * b_byte;
  assign prod_ext = (SIGNED_LANES != 0) ? {{16{prod_s[15]}}, prod_s}
                                        : {16'b0, prod_u};
  assign lane_sum = psum + prod_ext;
  // Value the accumulator takes when the final lane completes; wraps mod 2^32.
  assign acc_next = op_dotz ? lane_sum : (acc + lane_sum);

  // Control FSM, accumulator and registered PCPI outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= 32'd0;
      psum       <= 32'd0;
      lane       <= 2'd0;
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      op_dotz    <= 1'b0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= 32'd0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
    end else begin
      // Completion strobes are single-cycle unless set below.
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      case (state)
        IDLE: begin
          // Skipping the edge on which ready is already high keeps a still-held
          // valid from re-issuing the same single-cycle instruction.
          if (active && !pcpi_ready) begin
            if (insn_funct3[1]) begin
              // RDACC (010) / CLRACC (011): answer immediately.
              pcpi_ready <= 1'b1;
              pcpi_wr    <= 1'b1;
              if (insn_funct3[0]) begin
                acc     <= 32'd0;
                pcpi_rd <= 32'd0;
              end else begin
                pcpi_rd <= acc;
              end
            end else begin
              // DOT (000) / DOTZ (001): latch operands, start lane walk.
              op_a      <= pcpi_rs1;
              op_b      <= pcpi_rs2;
              op_dotz   <= insn_funct3[0];
              psum      <= 32'd0;
              lane      <= 2'd0;
              pcpi_wait <= 1'b1;
              state     <= MUL;
            end
          end
        end

        MUL: begin
          if (!pcpi_valid) begin
            // CPU withdrew the instruction: drop it, accumulator untouched.
            pcpi_wait <= 1'b0;
            state     <= IDLE;
          end else begin
            psum <= lane_sum;
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              acc        <= acc_next;
              pcpi_rd    <= acc_next;
              pcpi_ready <= 1'b1;
              pcpi_wr    <= 1'b1;
              pcpi_wait  <= 1'b0;
              state      <= DONE;
            end
          end
        end

        DONE: begin
          // One dead cycle so a stale valid cannot start another operation.
          pcpi_wait <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          pcpi_wait <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_dot8_mac.sv
// Bench for pcpi_dot8_mac: an unsigned-lane and a signed-lane instance share
// one PCPI input bus. Expected results are pushed per instance when an
// instruction is offered and popped when that instance pulses ready.
module tb_pcpi_dot8_mac;

  localparam logic [6:0] F7 = 7'b0000001;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;

  logic        u_wr, u_wait, u_ready;
  logic [31:0] u_rd;
  logic        s_wr, s_wait, s_ready;
  logic [31:0] s_rd;

  pcpi_dot8_mac #(.FUNCT7(F7), .SIGNED_LANES(0)) u_dut (
    .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(u_wr), .pcpi_rd(u_rd),
    .pcpi_wait(u_wait), .pcpi_ready(u_ready)
  );

  pcpi_dot8_mac #(.FUNCT7(F7), .SIGNED_LANES(1)) s_dut (
    .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(s_wr), .pcpi_rd(s_rd),
    .pcpi_wait(s_wait), .pcpi_ready(s_ready)
  );

  // Scoreboard state
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_u_q[$];
  logic [31:0] exp_s_q[$];
  logic [31:0] acc_u, acc_s;
  logic [31:0] last_u, last_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] make_insn(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  // Reference dot product: each lane widened to 32 bits, products mod 2^32.
  function automatic logic [31:0] dot_model(input logic [31:0] a, input logic [31:0] b,
                                            input bit sgn);
    logic [31:0] s;
    logic [31:0] xa, xb;
    s = 32'd0;
    for (int i = 0; i < 4; i++) begin
      xa = {24'd0, a[8*i +: 8]};
      xb = {24'd0, b[8*i +: 8]};
      if (sgn && a[8*i+7]) xa[31:8] = 24'hFFFFFF;
      if (sgn && b[8*i+7]) xb[31:8] = 24'hFFFFFF;
      s = s + xa * xb;
    end
    return s;
  endfunction

  // Update the accumulator models and push the rd each instance must return.
  task automatic model_push(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] su, ss;
    su = dot_model(a, b, 1'b0);
    ss = dot_model(a, b, 1'b1);
    case (f3)
      3'd0: begin acc_u = acc_u + su; acc_s = acc_s + ss; end
      3'd1: begin acc_u = su; acc_s = ss; end
      3'd3: begin acc_u = 32'd0; acc_s = 32'd0; end
      default: ;
    endcase
    exp_u_q.push_back(acc_u);
    exp_s_q.push_back(acc_s);
  endtask

  // Driver: offer a claimed instruction at a negedge, hold valid until ready,
  // then confirm the strobes were single-cycle. Returns at a negedge.
  task automatic run_insn(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit   done;
    bit   wait_ok;
    logic exp_wait;
    int   want_lat;
    want_lat = f3[1] ? 1 : 5;
    exp_wait = !f3[1];
    model_push(f3, a, b);
    pcpi_valid = 1'b1;
    pcpi_insn  = make_insn(F7, f3, 7'b0001011);
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    done    = 1'b0;
    wait_ok = 1'b1;
    for (int k = 1; k <= 12 && !done; k++) begin
      @(negedge clk);
      if (u_ready) begin
        done = 1'b1;
        check("latency", k, want_lat);
        check("wr_u", u_wr, 1'b1);
        check("wait_at_ready", {u_wait, s_wait}, 2'b00);
        check("ready_s", {s_ready, s_wr}, 2'b11);
        check("rd_u", u_rd, exp_u_q.pop_front());
        check("rd_s", s_rd, exp_s_q.pop_front());
        last_u = u_rd;
        last_s = s_rd;
        pcpi_valid = 1'b0;
      end else if (u_wait !== exp_wait || s_wait !== exp_wait) begin
        wait_ok = 1'b0;
      end
    end
    if (!done) begin
      check("ready_timeout", 32'd0, 32'd1);
      void'(exp_u_q.pop_front());
      void'(exp_s_q.pop_front());
      pcpi_valid = 1'b0;
    end
    check("wait_profile", wait_ok, 1'b1);
    @(negedge clk);
    check("pulse_width", {u_ready, u_wr, s_ready, s_wr}, 4'b0000);
  endtask

  // Offer an unclaimable instruction for 20 cycles; no strobe may move.
  task automatic no_claim(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    bit quiet;
    quiet = 1'b1;
    pcpi_valid = 1'b1;
    pcpi_insn  = make_insn(f7, f3, opc);
    pcpi_rs1   = 32'hFFFFFFFF;
    pcpi_rs2   = 32'hFFFFFFFF;
    repeat (20) begin
      @(negedge clk);
      if (u_wait || u_ready || u_wr || s_wait || s_ready || s_wr) quiet = 1'b0;
    end
    check("no_claim", quiet, 1'b1);
    pcpi_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit quiet;
    reset      = 1'b1;
    pcpi_valid = 1'b0;
    pcpi_insn  = 32'd0;
    pcpi_rs1   = 32'd0;
    pcpi_rs2   = 32'd0;
    acc_u = 32'd0;
    acc_s = 32'd0;
    last_u = 32'd0;
    last_s = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_outs_u", {u_wait, u_ready, u_wr}, 3'b000);
    check("reset_rd_u", u_rd, 32'd0);
    check("reset_outs_s", {s_wait, s_ready, s_wr}, 3'b000);
    reset = 1'b0;

    // Basic DOTZ / DOT / RDACC / CLRACC sequence
    run_insn(3'd1, 32'h01020304, 32'h05060708);
    check("dotz_basic", last_u, 32'h00000046);
    run_insn(3'd0, 32'h01020304, 32'h05060708);
    check("dot_basic", last_u, 32'h0000008C);
    run_insn(3'd2, 32'h0, 32'h0);
    check("rdacc_basic", last_u, 32'h0000008C);
    run_insn(3'd3, 32'h0, 32'h0);
    check("clracc", last_u, 32'h00000000);
    run_insn(3'd2, 32'h0, 32'h0);
    check("rdacc_after_clr", last_u, 32'h00000000);

    // Lane extremes for both signednesses, then a wrap through 2^32
    run_insn(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("max_u", last_u, 32'h0003F804);
    check("max_s", last_s, 32'h00000004);
    run_insn(3'd1, 32'h80808080, 32'h7F7F7F7F);
    check("neg_s", last_s, 32'hFFFF0200);
    run_insn(3'd0, 32'h80808080, 32'h80808080);
    check("wrap_s", last_s, 32'h00000200);

    // Randomized mix of all four claimed operations
    repeat (40) run_insn(3'($urandom_range(0, 3)), $urandom, $urandom);

    // Long run of back-to-back DOTs at maximum lane values
    run_insn(3'd3, 32'h0, 32'h0);
    repeat (300) run_insn(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("acc_300_u", last_u, 32'd78030000);
    check("acc_300_s", last_s, 32'd1200);

    // Instructions that must not be claimed
    no_claim(7'b0000000, 3'd0, 7'b0001011);
    no_claim(F7, 3'd4, 7'b0001011);
    no_claim(F7, 3'd7, 7'b0001011);
    no_claim(F7, 3'd0, 7'b0101011);
    run_insn(3'd2, 32'h0, 32'h0);
    check("acc_after_noclaim", last_u, 32'd78030000);

    // Abort: valid withdrawn during the second MUL cycle
    run_insn(3'd1, 32'h01020304, 32'h05060708);
    pcpi_valid = 1'b1;
    pcpi_insn  = make_insn(F7, 3'd0, 7'b0001011);
    pcpi_rs1   = 32'hFFFFFFFF;
    pcpi_rs2   = 32'hFFFFFFFF;
    @(negedge clk);
    check("abort_wait_hi", {u_wait, s_wait}, 2'b11);
    @(negedge clk);
    pcpi_valid = 1'b0;
    @(negedge clk);
    check("abort_wait_lo", {u_wait, s_wait}, 2'b00);
    quiet = 1'b1;
    repeat (8) begin
      if (u_ready || u_wr || s_ready || s_wr || u_wait || s_wait) quiet = 1'b0;
      @(negedge clk);
    end
    check("abort_no_ready", quiet, 1'b1);
    run_insn(3'd2, 32'h0, 32'h0);
    check("acc_after_abort", last_u, 32'h00000046);

    // Reset asserted during the third MUL cycle
    pcpi_valid = 1'b1;
    pcpi_insn  = make_insn(F7, 3'd0, 7'b0001011);
    pcpi_rs1   = 32'h01010101;
    pcpi_rs2   = 32'h02020202;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midop_reset_u", {u_wait, u_ready, u_wr}, 3'b000);
    check("midop_reset_rd", u_rd, 32'd0);
    check("midop_reset_s", {s_wait, s_ready, s_wr}, 3'b000);
    reset      = 1'b0;
    pcpi_valid = 1'b0;
    acc_u = 32'd0;
    acc_s = 32'd0;
    @(negedge clk);
    run_insn(3'd2, 32'h0, 32'h0);
    check("acc_after_reset", last_u, 32'd0);

    check("queues_drained", exp_u_q.size() + exp_s_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
